serial_cmd_master: RTL

//  Initiator end of the board serial command protocol: issues one opcode plus argument bytes over a UART
//  TX handshake, then collects the fixed-length response over the UART RX strobe and streams it out.

---
 rtl/serial_cmd_pkg.sv | 71 +++++++
 rtl/serial_cmd_master.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_cmd_pkg.sv
// Package: serial_cmd_pkg
// Shared definitions for the serial command master:
//   - opcode values of the remote trigger board's command processor
//   - completion status codes
//   - FSM state encoding
//   - cmd_lengths(): per-opcode argument and response byte counts
// Ports: none (package).
package serial_cmd_pkg;

    localparam logic [7:0] CMD_VERSION        = 8'd0;
    localparam logic [7:0] CMD_SET_COINC      = 8'd1;
    localparam logic [7:0] CMD_SET_DEADTIME   = 8'd2;
    localparam logic [7:0] CMD_START_HISTO    = 8'd3;
    localparam logic [7:0] CMD_STOP_HISTO     = 8'd4;
    localparam logic [7:0] CMD_CLEAR_HISTO    = 8'd5;
    localparam logic [7:0] CMD_SET_SEED       = 8'd6;
    localparam logic [7:0] CMD_SET_PRESCALE   = 8'd7;
    localparam logic [7:0] CMD_GET_STATUS     = 8'd8;
    localparam logic [7:0] CMD_ARM            = 8'd9;
    localparam logic [7:0] CMD_READ_HISTOS    = 8'd10;
    localparam logic [7:0] CMD_SET_CLKSEL     = 8'd11;
    localparam logic [7:0] CMD_PLL_RESET      = 8'd12;
    localparam logic [7:0] CMD_CLK_SWITCH     = 8'd13;
    localparam logic [7:0] CMD_SET_TRIG_MASK  = 8'd14;
    localparam logic [7:0] CMD_SET_MODE       = 8'd15;
    localparam logic [7:0] CMD_READ_CLOCK     = 8'd16;
    localparam logic [7:0] CMD_RESET_CLOCK    = 8'd17;

    localparam logic [1:0] STATUS_OK      = 2'd0;
    localparam logic [1:0] STATUS_UNKNOWN = 2'd1;
    localparam logic [1:0] STATUS_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_SEND,
        ST_SEND_GAP,
        ST_RECV,
        ST_FINISH,
        ST_GUARD
    } state_t;

    // Returns {known, nargs[3:0], nrsp[5:0]}.
    function automatic logic [10:0] cmd_lengths(input logic [7:0] opcode);
        logic [10:0] r;
        r = {1'b0, 4'd0, 6'd0};
        case (opcode)
            CMD_VERSION:       r = {1'b1, 4'd0, 6'd1};
            CMD_SET_COINC:     r = {1'b1, 4'd1, 6'd0};
            CMD_SET_DEADTIME:  r = {1'b1, 4'd1, 6'd0};
            CMD_START_HISTO:   r = {1'b1, 4'd0, 6'd0};
            CMD_STOP_HISTO:    r = {1'b1, 4'd0, 6'd0};
            CMD_CLEAR_HISTO:   r = {1'b1, 4'd0, 6'd0};
            CMD_SET_SEED:      r = {1'b1, 4'd4, 6'd0};
            CMD_SET_PRESCALE:  r = {1'b1, 4'd4, 6'd0};
            CMD_GET_STATUS:    r = {1'b1, 4'd0, 6'd1};
            CMD_ARM:           r = {1'b1, 4'd0, 6'd0};
            CMD_READ_HISTOS:   r = {1'b1, 4'd0, 6'd32};
            CMD_SET_CLKSEL:    r = {1'b1, 4'd1, 6'd0};
            CMD_PLL_RESET:     r = {1'b1, 4'd0, 6'd0};
            CMD_CLK_SWITCH:    r = {1'b1, 4'd0, 6'd0};
            CMD_SET_TRIG_MASK: r = {1'b1, 4'd8, 6'd0};
            CMD_SET_MODE:      r = {1'b1, 4'd1, 6'd0};
            CMD_READ_CLOCK:    r = {1'b1, 4'd0, 6'd8};
            CMD_RESET_CLOCK:   r = {1'b1, 4'd0, 6'd1};
            default:           r = {1'b0, 4'd0, 6'd0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/serial_cmd_master.sv
// Module: serial_cmd_master
// Initiator of the board serial command protocol. Sends opcode + argument
// bytes through a UART TX handshake, then streams the fixed-length response
// collected from UART RX strobes. After each command a guard interval lets
// the remote board settle before cmd_ready returns.
//
// Optional feature: define SERIAL_CMD_TIMEOUT_EN to enable a per-byte
// response timeout (status 2). Without it RECV waits indefinitely.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_opcode, cmd_args       command byte and argument bytes (byte 0 = [7:0], sent first)
//   tx_busy, tx_start, tx_data UART transmit handshake
//   rx_ready, rx_data          UART receive strobe and byte
//   rsp_valid, rsp_byte, rsp_index  response stream
//   done, status               completion pulse and held status
//   stray_count                saturating count of rx bytes seen outside RECV
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | guard counting down; ready for a command once it is 0
// LOOKUP    | decode opcode into argument/response lengths
// SEND      | wait for !tx_busy, launch next byte
// SEND_GAP  | one cycle for the UART to raise tx_busy
// RECV      | collect response bytes
// FINISH    | pulse done, publish status, load guard
// GUARD     | settle interval before returning to IDLE
module serial_cmd_master
    import serial_cmd_pkg::*;
#(
    parameter int GUARD_CYCLES   = 256,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_opcode,
    input  logic [63:0] cmd_args,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_byte,
    output logic [5:0]  rsp_index,
    output logic        done,
    output logic [1:0]  status,
    output logic [7:0]  stray_count
);

    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES);

    if (GUARD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("serial_cmd_master: GUARD_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    state_t        state;
    logic [GW-1:0] guard_cnt;
    logic [7:0]    opcode_r;
    logic [63:0]   args_r;
    logic [3:0]    nargs_r;
    logic [5:0]    nrsp_r;
    logic [3:0]    byte_cnt;
    logic [5:0]    rsp_cnt;
    logic [1:0]    fin_status;
    logic [10:0]   lens;

`ifdef SERIAL_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);
    logic [TW-1:0] tmo_cnt;
`endif

    assign lens = cmd_lengths(opcode_r);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            guard_cnt   <= GUARD_LOAD;
            cmd_ready   <= 1'b0;
            opcode_r    <= 8'd0;
            args_r      <= 64'd0;
            nargs_r     <= 4'd0;
            nrsp_r      <= 6'd0;
            byte_cnt    <= 4'd0;
            rsp_cnt     <= 6'd0;
            fin_status  <= STATUS_OK;
            tx_start    <= 1'b0;
            tx_data     <= 8'd0;
            rsp_valid   <= 1'b0;
            rsp_byte    <= 8'd0;
            rsp_index   <= 6'd0;
            done        <= 1'b0;
            status      <= STATUS_OK;
            stray_count <= 8'd0;
`ifdef SERIAL_CMD_TIMEOUT_EN
            tmo_cnt     <= TMO_LOAD;
`endif
        end else begin
            tx_start  <= 1'b0;
            rsp_valid <= 1'b0;
            done      <= 1'b0;

            // Bytes arriving outside RECV (including the cycle that enters it) are discarded.
            if (rx_ready && state != ST_RECV && stray_count != 8'hFF)
                stray_count <= stray_count + 8'd1;

            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        opcode_r  <= cmd_opcode;
                        args_r    <= cmd_args;
                        status    <= STATUS_OK;
                        cmd_ready <= 1'b0;
                        state     <= ST_LOOKUP;
                    end else if (guard_cnt != '0) begin
                        guard_cnt <= guard_cnt - 1'b1;
                        cmd_ready <= (guard_cnt == GW'(1));
                    end
                end
                ST_LOOKUP: begin
                    if (!lens[10]) begin
                        fin_status <= STATUS_UNKNOWN;
                        state      <= ST_FINISH;
                    end else begin
                        nargs_r  <= lens[9:6];
                        nrsp_r   <= lens[5:0];
                        byte_cnt <= 4'd0;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        if (byte_cnt == 4'd0) begin
                            tx_data <= opcode_r;
                        end else begin
                            // Arguments leave from the low byte; shift to expose the next one.
                            tx_data <= args_r[7:0];
                            args_r  <= args_r >> 8;
                        end
                        state <= ST_SEND_GAP;
                    end
                end
                ST_SEND_GAP: begin
                    if (byte_cnt != nargs_r) begin
                        byte_cnt <= byte_cnt + 4'd1;
                        state    <= ST_SEND;
                    end else if (nrsp_r != 6'd0) begin
                        rsp_cnt <= 6'd0;
`ifdef SERIAL_CMD_TIMEOUT_EN
                        tmo_cnt <= TMO_LOAD;
`endif
                        state   <= ST_RECV;
                    end else begin
                        fin_status <= STATUS_OK;
                        state      <= ST_FINISH;
                    end
                end
                ST_RECV: begin
                    if (rx_ready) begin
                        rsp_valid <= 1'b1;
                        rsp_byte  <= rx_data;
                        rsp_index <= rsp_cnt;
`ifdef SERIAL_CMD_TIMEOUT_EN
                        tmo_cnt   <= TMO_LOAD;
`endif
                        if (rsp_cnt == nrsp_r - 6'd1) begin
                            fin_status <= STATUS_OK;
                            state      <= ST_FINISH;
                        end else begin
                            rsp_cnt <= rsp_cnt + 6'd1;
                        end
                    end
`ifdef SERIAL_CMD_TIMEOUT_EN
                    else if (tmo_cnt == TW'(1)) begin
                        tmo_cnt    <= '0;
                        fin_status <= STATUS_TIMEOUT;
                        state      <= ST_FINISH;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
`endif
                end
                ST_FINISH: begin
                    done      <= 1'b1;
                    status    <= fin_status;
                    guard_cnt <= GUARD_LOAD;
                    state     <= ST_GUARD;
                end
                ST_GUARD: begin
                    if (guard_cnt <= GW'(1)) begin
                        guard_cnt <= '0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        guard_cnt <= guard_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
